// File: rtl/axi_lite_master.sv
// ---------------------------------------------------------------------------
// axi_lite_master
//   Turns a simple one-at-a-time command/response interface into AXI4-Lite
//   transactions. Only one transaction is outstanding at a time.
//
//   Optional feature macro: AXIL_MASTER_TIMEOUT_EN
//     When defined, the block gives up on a missing B/R response after 255
//     waiting cycles and reports SLVERR (2'b10) with zero data.
//
//   Handshake rule for every valid/ready pair on this block:
//     a transfer happens on the rising clk edge where valid && ready are both
//     high. Once valid is raised, it and its payload stay unchanged until that
//     edge.
//
//   Ports
//     clk, reset        : clock, asynchronous active-low reset
//     cmd_*             : command request (valid/ready, write, addr, wdata, wstrb)
//     rsp_*             : result (valid/ready, rdata, resp)
//     aw*/w*/b*         : AXI4-Lite write channels
//     ar*/r*            : AXI4-Lite read channels
//     o_dbg_state       : current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module axi_lite_master #(
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_ADDR_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [AXIL_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [AXIL_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [AXIL_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [AXIL_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                   rsp_resp,
    output logic                         awvalid,
    input  logic                         awready,
    output logic [AXIL_ADDR_WIDTH-1:0]   awaddr,
    output logic                         wvalid,
    input  logic                         wready,
    output logic [AXIL_DATA_WIDTH-1:0]   wdata,
    output logic [AXIL_DATA_WIDTH/8-1:0] wstrb,
    input  logic                         bvalid,
    output logic                         bready,
    input  logic [1:0]                   bresp,
    output logic                         arvalid,
    input  logic                         arready,
    output logic [AXIL_ADDR_WIDTH-1:0]   araddr,
    input  logic                         rvalid,
    output logic                         rready,
    input  logic [AXIL_DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]                   rresp,
    output logic [2:0]                   o_dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                         r_state;
    state_t                         w_next_state;

    logic                           r_awvalid;
    logic                           r_wvalid;
    logic                           r_bready;
    logic                           r_arvalid;
    logic                           r_rready;
    logic                           r_rsp_valid;
    logic [AXIL_ADDR_WIDTH-1:0]     r_awaddr;
    logic [AXIL_ADDR_WIDTH-1:0]     r_araddr;
    logic [AXIL_DATA_WIDTH-1:0]     r_wdata;
    logic [AXIL_DATA_WIDTH/8-1:0]   r_wstrb;
    logic [AXIL_DATA_WIDTH-1:0]     r_rsp_rdata;
    logic [1:0]                     r_rsp_resp;

    // A channel counts as finished if it already completed earlier or
    // completes on this edge; this lets AW and W finish in either order.
    logic                           w_aw_done;
    logic                           w_w_done;
    logic                           w_timeout;

    assign w_aw_done = ~r_awvalid | awready;
    assign w_w_done  = ~r_wvalid  | wready;

`ifdef AXIL_MASTER_TIMEOUT_EN
    logic [7:0] r_wait_cnt;

    // Counter sits at zero outside the response states, so it starts from
    // zero on entry; the 255th waiting cycle sees a count of 254.
    assign w_timeout = ((r_state == WR_RESP) || (r_state == RD_RESP)) &&
                       (r_wait_cnt == 8'd254);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= 8'd0;
        end else if ((r_state == WR_RESP) || (r_state == RD_RESP)) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end else begin
            r_wait_cnt <= 8'd0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (cmd_valid)              w_next_state = cmd_write ? WR_REQ : RD_REQ;
            WR_REQ:  if (w_aw_done && w_w_done)  w_next_state = WR_RESP;
            WR_RESP: if (bvalid || w_timeout)    w_next_state = DONE;
            RD_REQ:  if (arready)                w_next_state = RD_RESP;
            RD_RESP: if (rvalid || w_timeout)    w_next_state = DONE;
            DONE:    if (rsp_ready)              w_next_state = IDLE;
            default:                             w_next_state = IDLE;
        endcase
    end

    // Registered AXI and response outputs, updated on the same conditions
    // that move the FSM so every output changes together with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_awaddr  <= cmd_addr;
                            r_wdata   <= cmd_wdata;
                            r_wstrb   <= cmd_wstrb;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_araddr  <= cmd_addr;
                        end
                    end
                end
                WR_REQ: begin
                    if (awready)                r_awvalid <= 1'b0;
                    if (wready)                 r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done)  r_bready  <= 1'b1;
                end
                WR_RESP: begin
                    if (bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_resp  <= bresp;
                        r_rsp_rdata <= '0;
                    end else if (w_timeout) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_resp  <= 2'b10;
                        r_rsp_rdata <= '0;
                    end
                end
                RD_REQ: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_resp  <= rresp;
                        r_rsp_rdata <= rdata;
                    end else if (w_timeout) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_resp  <= 2'b10;
                        r_rsp_rdata <= '0;
                    end
                end
                DONE: begin
                    if (rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready   = (r_state == IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_resp    = r_rsp_resp;
    assign awvalid     = r_awvalid;
    assign awaddr      = r_awaddr;
    assign wvalid      = r_wvalid;
    assign wdata       = r_wdata;
    assign wstrb       = r_wstrb;
    assign bready      = r_bready;
    assign arvalid     = r_arvalid;
    assign araddr      = r_araddr;
    assign rready      = r_rready;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axi_lite_master.sv
// Testbench for axi_lite_master: scripted AXI slave behaviour, response
// scoreboard with an expected queue, and a single summary line.
module tb_axi_lite_master;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int SW = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;
  logic          arvalid, arready, rvalid, rready;
  logic [2:0]    dbg_state;

  axi_lite_master #(.AXIL_DATA_WIDTH(DW), .AXIL_ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DW+1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue_cmd(input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [SW-1:0] ws);
    int cnt;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    cnt = 0;
    while (!cmd_ready && cnt < 50) begin
      step();
      cnt++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  // Slave AW/W acceptance: awready rises after aw_dly cycles, wready after w_dly.
  task automatic wr_req(input int aw_dly, input int w_dly, input logic [AW-1:0] ea,
                        input logic [DW-1:0] ed, input logic [SW-1:0] es);
    check("awvalid_rise", awvalid, 1);
    check("wvalid_rise", wvalid, 1);
    check("awaddr", awaddr, ea);
    check("wdata", wdata, ed);
    check("wstrb", wstrb, es);
    for (int c = 0; c < 40; c++) begin
      awready = (c >= aw_dly);
      wready  = (c >= w_dly);
      step();
      check("awvalid_seq", awvalid, (c < aw_dly));
      check("wvalid_seq", wvalid, (c < w_dly));
      if (awvalid) check("awaddr_hold", awaddr, ea);
      if (wvalid) check("wdata_hold", {wstrb, wdata}, {es, ed});
      if (!awvalid && !wvalid) break;
    end
    awready = 1'b0;
    wready  = 1'b0;
    check("bready_on", bready, 1);
  endtask

  task automatic wr_resp(input int dly, input logic [1:0] br);
    for (int c = 0; c < dly; c++) begin
      step();
      check("bready_hold", bready, 1);
      check("rsp_valid_early", rsp_valid, 0);
    end
    bvalid = 1'b1; bresp = br;
    step();
    bvalid = 1'b0; bresp = 2'b00;
    check("bready_off", bready, 0);
  endtask

  task automatic rd_req(input int ar_dly, input logic [AW-1:0] ea);
    check("arvalid_rise", arvalid, 1);
    check("araddr", araddr, ea);
    for (int c = 0; c < ar_dly; c++) begin
      step();
      check("arvalid_hold", {arvalid, araddr}, {1'b1, ea});
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("arvalid_off", arvalid, 0);
    check("rready_on", rready, 1);
  endtask

  task automatic rd_resp(input int dly, input logic [DW-1:0] d, input logic [1:0] rr);
    for (int c = 0; c < dly; c++) begin
      step();
      check("rready_hold", rready, 1);
      check("rsp_valid_early", rsp_valid, 0);
    end
    rvalid = 1'b1; rdata = d; rresp = rr;
    step();
    rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    check("rready_off", rready, 0);
  endtask

  // Pop the scoreboard and compare against the response, after holding
  // rsp_ready low for 'hold' cycles.
  task automatic get_rsp(input int hold);
    logic [DW+1:0] exp;
    int cnt;
    cnt = 0;
    while (!rsp_valid && cnt < 400) begin
      step();
      cnt++;
    end
    check("rsp_valid_wait", rsp_valid, 1);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 1, 0);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    for (int c = 0; c < hold; c++) begin
      step();
      check("rsp_hold_valid", rsp_valid, 1);
      check("rsp_hold_data", {rsp_rdata, rsp_resp}, exp);
      check("cmd_ready_busy", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    check("rsp_data", {rsp_rdata, rsp_resp}, exp);
    step();
    rsp_ready = 1'b0;
    check("rsp_valid_off", rsp_valid, 0);
    check("cmd_ready_back", cmd_ready, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [1:0]    r;

    reset = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = '0; rresp = 0;
    repeat (3) step();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_valids", {rsp_valid, awvalid, wvalid, bready, arvalid, rready}, 6'b0);
    check("rst_data", {awaddr, araddr, wdata, wstrb}, '0);
    check("rst_rsp", {rsp_rdata, rsp_resp}, '0);
    reset = 1'b1;
    step();

    // Stray slave signals while idle must be ignored.
    bvalid = 1; rvalid = 1; awready = 1; arready = 1; wready = 1;
    step();
    bvalid = 0; rvalid = 0; awready = 0; arready = 0; wready = 0;
    check("idle_ignore_state", dbg_state, 3'd0);
    check("idle_ignore_rsp", rsp_valid, 0);

    // Write, slave ready immediately.
    exp_q.push_back({32'h0, 2'b00});
    issue_cmd(1'b1, 4'd3, 32'hDEADBEEF, 4'hF);
    wr_req(0, 0, 4'd3, 32'hDEADBEEF, 4'hF);
    wr_resp(0, 2'b00);
    get_rsp(0);

    // Write with W accepted three cycles before AW.
    exp_q.push_back({32'h0, 2'b01});
    issue_cmd(1'b1, 4'd9, 32'hA5A55A5A, 4'h6);
    wr_req(3, 0, 4'd9, 32'hA5A55A5A, 4'h6);
    wr_resp(1, 2'b01);
    get_rsp(0);
    step();
    check("single_rsp", rsp_valid, 0);

    // Read addr 5, rvalid after 4 cycles.
    exp_q.push_back({32'h12345678, 2'b00});
    issue_cmd(1'b0, 4'd5, '0, '0);
    rd_req(1, 4'd5);
    rd_resp(4, 32'h12345678, 2'b00);
    get_rsp(0);

    // Response back-pressure for 10 cycles.
    exp_q.push_back({32'hCAFEF00D, 2'b11});
    issue_cmd(1'b0, 4'd12, '0, '0);
    rd_req(0, 4'd12);
    rd_resp(2, 32'hCAFEF00D, 2'b11);
    get_rsp(10);

    // Reset in WR_RESP: outputs clear asynchronously, no response left.
    issue_cmd(1'b1, 4'd7, 32'h0BADC0DE, 4'h3);
    wr_req(0, 1, 4'd7, 32'h0BADC0DE, 4'h3);
    check("pre_reset_state", dbg_state, 3'd2);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_valids", {rsp_valid, awvalid, wvalid, bready, arvalid, rready}, 6'b0);
    check("async_rst_data", {awaddr, wdata, wstrb, rsp_rdata, rsp_resp}, '0);
    check("async_rst_state", dbg_state, 3'd0);
    step();
    reset = 1'b1;
    step();
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_bready", bready, 0);

    // Random mix of transactions.
    for (int i = 0; i < 8; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      d  = $urandom;
      r  = 2'($urandom_range(0, 3));
      if (wr) begin
        exp_q.push_back({32'h0, r});
        issue_cmd(1'b1, a, d, 4'($urandom_range(0, 15)));
        wr_req($urandom_range(0, 3), $urandom_range(0, 3), a, d, wstrb);
        wr_resp($urandom_range(0, 3), r);
      end else begin
        exp_q.push_back({d, r});
        issue_cmd(1'b0, a, '0, '0);
        rd_req($urandom_range(0, 3), a);
        rd_resp($urandom_range(0, 3), d, r);
      end
      get_rsp($urandom_range(0, 2));
    end

`ifdef AXIL_MASTER_TIMEOUT_EN
    // Read with no rvalid: timeout after 255 waiting cycles.
    begin
      int waited;
      exp_q.push_back({32'h0, 2'b10});
      issue_cmd(1'b0, 4'd1, '0, '0);
      rd_req(0, 4'd1);
      waited = 0;
      while (!rsp_valid && waited < 400) begin
        step();
        waited++;
      end
      check("timeout_cycles", waited, 255);
      check("timeout_rready", rready, 0);
      get_rsp(0);
    end
`endif

    check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter AXIL_DATA_WIDTH, 32, AXI data and command data width; byte strobes are AXIL_DATA_WIDTH/8.
REQ-002 SHALL have parameter AXIL_ADDR_WIDTH, 4, AXI and command address width.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid  in  1  command request.
REQ-006 SHALL have port cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_write  in  1  1=write, 0=read.
REQ-008 SHALL have port cmd_addr  in  AXIL_ADDR_WIDTH  target address.
REQ-009 SHALL have port cmd_wdata  in  AXIL_DATA_WIDTH  write data.
REQ-010 SHALL have port cmd_wstrb  in  AXIL_DATA_WIDTH/8  write byte strobes.
REQ-011 SHALL have port rsp_valid  out  1  result available.
REQ-012 SHALL have port rsp_ready  in  1  result consumed.
REQ-013 SHALL have port rsp_rdata  out  AXIL_DATA_WIDTH  read data; 0 for writes.
REQ-014 SHALL have port rsp_resp  out  2  captured bresp/rresp.
REQ-015 SHALL have port awvalid  out  1  AXI write address valid.
REQ-016 SHALL have port awready  in  1  AXI write address ready.
REQ-017 SHALL have port awaddr  out  AXIL_ADDR_WIDTH  AXI write address.
REQ-018 SHALL have port wvalid  out  1  AXI write data valid.
REQ-019 SHALL have port wready  in  1  AXI write data ready.
REQ-020 SHALL have port wdata  out  AXIL_DATA_WIDTH  AXI write data.
REQ-021 SHALL have port wstrb  out  AXIL_DATA_WIDTH/8  AXI write strobes.
REQ-022 SHALL have port bvalid  in  1  AXI write response valid.
REQ-023 SHALL have port bready  out  1  AXI write response ready.
REQ-024 SHALL have port bresp  in  2  AXI write response.
REQ-025 SHALL have port arvalid  out  1  AXI read address valid.
REQ-026 SHALL have port arready  in  1  AXI read address ready.
REQ-027 SHALL have port araddr  out  AXIL_ADDR_WIDTH  AXI read address.
REQ-028 SHALL have port rvalid  in  1  AXI read data valid.
REQ-029 SHALL have port rready  out  1  AXI read data ready.
REQ-030 SHALL have port rdata  in  AXIL_DATA_WIDTH  AXI read data.
REQ-031 SHALL have port rresp  in  2  AXI read response.

Function
REQ-032 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE, with one outstanding transaction.
REQ-033 SHALL assert cmd_ready only in IDLE; on cmd_valid&&cmd_ready, register addr/wdata/wstrb and go to WR_REQ (cmd_write=1) or RD_REQ (cmd_write=0).
REQ-034 SHALL register all AXI outputs; awvalid/wvalid or arvalid rise exactly one cycle after command acceptance.
REQ-035 In WR_REQ, SHALL drop awvalid and wvalid independently on their own handshakes, in either order or the same cycle, and enter WR_RESP after both complete.
REQ-036 SHALL hold every asserted valid and its address/data/strobe stable until the matching ready is sampled high.
REQ-037 SHALL hold arvalid in RD_REQ until arready, then enter RD_RESP.
REQ-038 SHALL hold bready high in WR_RESP and rready high in RD_RESP; on bvalid/rvalid, capture bresp or rdata+rresp and enter DONE; bready and rready SHALL be low in all other states.
REQ-039 SHALL hold rsp_valid high in DONE with stable rsp_rdata/rsp_resp until rsp_ready, then return to IDLE; the earliest new acceptance is the cycle after rsp_ready.
REQ-040 SHALL ignore awready/wready/bvalid/arready/rvalid outside their waiting states.

Reset
REQ-041 SHALL, on reset low at any time (including mid-transaction), go to IDLE with cmd_ready=1 and rsp_valid, awvalid, wvalid, bready, arvalid, rready=0, all data/address/resp outputs=0.

Configuration
REQ-042 With macro AXIL_MASTER_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entering WR_RESP/RD_RESP and increment each waiting cycle; after 255 cycles without response, the block SHALL drop bready/rready, enter DONE with rsp_resp=2'b10 and rsp_rdata=0.
REQ-043 Without AXIL_MASTER_TIMEOUT_EN, no counter SHALL exist and WR_RESP/RD_RESP SHALL wait indefinitely.

Verification
REQ-044 Write addr=3, wdata=32'hDEADBEEF, wstrb=4'hF, slave ready immediately -> awvalid/wvalid high one cycle, bready until bvalid, rsp_valid with rsp_resp=2'b00.
REQ-045 Write with wready 3 cycles before awready -> wvalid drops first, awvalid held with awaddr stable, single rsp_valid afterwards.
REQ-046 Read addr=5, rvalid after 4 cycles with rdata=32'h12345678, rresp=2'b00 -> rsp_rdata=32'h12345678, rsp_resp=2'b00.
REQ-047 rsp_ready held low 10 cycles -> rsp_valid and data stable, cmd_ready low throughout.
REQ-048 Reset asserted in WR_RESP -> all AXI valids/readies low asynchronously, cmd_ready=1 after release.
REQ-049 With AXIL_MASTER_TIMEOUT_EN, read with rvalid never asserted -> rsp_valid after 255 cycles with rsp_resp=2'b10.
